// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the EX-stage ALU control slice: ALU codes, funct/opcode
// values, ALUOp classes and the mul/div sequencer state encoding.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;
    localparam logic [3:0] ALU_NOR  = 4'b1100;
    localparam logic [3:0] ALU_LUI  = 4'b1101;
    localparam logic [3:0] ALU_NOP  = 4'b1111;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational ALU control decode; also flags mul/div ops and every
// instruction that touches HI/LO.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [5:0] funct_i,
    input  logic [5:0] opcode_i,
    output logic [3:0] code_o,
    output logic       is_md_o,
    output logic       is_hilo_o
);

    always_comb begin
        code_o    = ALU_ADD;
        is_md_o   = 1'b0;
        is_hilo_o = 1'b0;
        case (alu_op_i)
            ALUOP_MEM: code_o = ALU_ADD;
            ALUOP_BR:  code_o = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct_i)
                    FN_ADD:  code_o = ALU_ADD;
                    FN_SUB:  code_o = ALU_SUB;
                    FN_AND:  code_o = ALU_AND;
                    FN_OR:   code_o = ALU_OR;
                    FN_XOR:  code_o = ALU_XOR;
                    FN_NOR:  code_o = ALU_NOR;
                    FN_SLT:  code_o = ALU_SLT;
                    FN_SLTU: code_o = ALU_SLTU;
                    FN_SLL:  code_o = ALU_SLL;
                    FN_SRL:  code_o = ALU_SRL;
                    FN_SRA:  code_o = ALU_SRA;
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        code_o    = ALU_NOP;
                        is_md_o   = 1'b1;
                        is_hilo_o = 1'b1;
                    end
                    // mfhi/mflo keep the default code; they only matter for hazards
                    FN_MFHI, FN_MFLO: is_hilo_o = 1'b1;
                    default: code_o = ALU_ADD;
                endcase
            end
            ALUOP_ITYPE: begin
                case (opcode_i)
                    OP_ANDI:  code_o = ALU_AND;
                    OP_ORI:   code_o = ALU_OR;
                    OP_XORI:  code_o = ALU_XOR;
                    OP_SLTI:  code_o = ALU_SLT;
                    OP_SLTIU: code_o = ALU_SLTU;
                    OP_LUI:   code_o = ALU_LUI;
                    default:  code_o = ALU_ADD;
                endcase
            end
            default: code_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control stage with a mul/div sequencer that counts the
// iterative unit's latency and stalls HI/LO consumers while it runs.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter  int CTRL_W    = 4,
    parameter  int MD_CYCLES = 32,
    localparam int CNT_W     = $clog2(MD_CYCLES)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid_in,
    input  logic [1:0]        ALUOp,
    input  logic [5:0]        Funct,
    input  logic [5:0]        Opcode,
    input  logic              stall_in,
    input  logic              flush,
    output logic [CTRL_W-1:0] ALUControl,
    output logic              ctrl_valid,
    output logic              md_start,
    output logic [1:0]        md_op,
    output logic              md_busy,
    output logic              md_done,
    output logic              stall_req
);

    logic [3:0]        dec_code;
    logic              dec_is_md;
    logic              dec_is_hilo;

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              valid_q, valid_d;
    logic              start_q, start_d;
    logic [1:0]        op_q, op_d;
    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              in_run;
    logic              load;
    logic              issue;

    alu_ctrl_decode u_decode (
        .alu_op_i  (ALUOp),
        .funct_i   (Funct),
        .opcode_i  (Opcode),
        .code_o    (dec_code),
        .is_md_o   (dec_is_md),
        .is_hilo_o (dec_is_hilo)
    );

    assign in_run    = (state_q == ST_RUN);
    assign stall_req = valid_in & ~flush & dec_is_hilo & in_run;
    assign load      = ~flush & ~stall_in & ~stall_req;
    assign issue     = load & valid_in & dec_is_md &
                       ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (stall_in) begin
            valid_d = valid_q;
        end else if (stall_req) begin
            valid_d = 1'b0;
        end else begin
            ctrl_d  = CTRL_W'(dec_code);
            valid_d = valid_in;
        end
    end

    // The counter runs independently of stall_in/flush so the mul/div unit
    // and this sequencer can never disagree about when the result is ready.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = issue;
        op_d    = issue ? Funct[1:0] : op_q;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_W'(MD_CYCLES - 1);
                end
            end
            ST_RUN: begin
                if (cnt_q == '0) state_d = ST_DONE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_DONE: begin
                if (issue) begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_W'(MD_CYCLES - 1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl_q  <= CTRL_W'(ALU_ADD);
            valid_q <= 1'b0;
            start_q <= 1'b0;
            op_q    <= 2'b00;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            start_q <= start_d;
            op_q    <= op_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ALUControl = ctrl_q;
    assign ctrl_valid = valid_q;
    assign md_start   = start_q;
    assign md_op      = op_q;
    assign md_busy    = in_run;
    assign md_done    = (state_q == ST_DONE);

endmodule

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Registered, parametrised ALU control stage for the EX end of the ID/EX pipeline register.
- Decodes ALUOp/Funct, and for I-type ops also Opcode, into a CTRL_W-bit ALU control word.
- Adds a sequencer for multi-cycle MULT/MULTU/DIV/DIVU that issues a start pulse and counts MD_CYCLES.
- Requests a pipeline stall on HI/LO hazards; drives the hazard unit and the iterative mul/div datapath.

Parameters:
- CTRL_W, 4, ALU control word width; must be at least 4.
- MD_CYCLES, 32, execution cycles of a mul/div op; legal range 2..64.
- CNT_W, $clog2(MD_CYCLES), width of the mul/div cycle counter; derived, not overridden.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset, sampled on rising clk
- valid_in  in  1  instruction present at the EX input
- ALUOp  in  2  main-control ALU class
- Funct  in  6  R-type funct field
- Opcode  in  6  instruction opcode; used only when ALUOp=11
- stall_in  in  1  hold from the hazard unit: freezes the output register
- flush  in  1  kill the instruction at the EX input
- ALUControl  out  CTRL_W  registered ALU control word
- ctrl_valid  out  1  ALUControl is for a live instruction
- md_start  out  1  one-cycle start pulse to the mul/div unit
- md_op  out  2  latched op: 00 mult, 01 multu, 10 div, 11 divu
- md_busy  out  1  mul/div op in progress
- md_done  out  1  one-cycle pulse on completion
- stall_req  out  1  combinational HI/LO hazard request

Behaviour:
- Reset (reset_n=0 at clk edge): ALUControl=0010, ctrl_valid=0, md_start=0, md_op=00, md_busy=0, md_done=0, state=IDLE, counter=0. Reset mid-operation abandons the op with no md_done.
- Decode, combinational:
  - ALUOp=00: 0010.
  - ALUOp=01: 0110.
  - ALUOp=10, by Funct: 100000 add 0010, 100010 sub 0110, 100100 and 0000, 100101 or 0001, 100110 xor 0011, 100111 nor 1100, 101010 slt 0111, 101011 sltu 1011, 000000 sll 1000, 000010 srl 1001, 000011 sra 1010.
  - ALUOp=10, MD class (011000, 011001, 011010, 011011): 1111 (ALU no-op).
  - ALUOp=11, by Opcode: 001100 andi 0000, 001101 ori 0001, 001110 xori 0011, 001010 slti 0111, 001011 sltiu 1011, 001111 lui 1101.
  - Any other code: 0010.
  - CTRL_W>4: upper bits are zero.
- HI/LO class: the MD functs plus mfhi 010000 and mflo 010010.
- stall_req = valid_in & ~flush & HI/LO class & (state==RUN).
- Output register priority per edge: reset > flush > stall_in > stall_req > load.
  - flush: ctrl_valid<=0; ALUControl holds.
  - stall_in: all outputs hold.
  - stall_req: bubble, ctrl_valid<=0.
  - load: ALUControl<=decode, ctrl_valid<=valid_in.
  - Latency: 1 cycle.
- Issue: the input register loads with valid_in=1, an MD funct, and state IDLE or DONE. On that edge md_start pulses for 1 cycle, md_op latches Funct[1:0], counter<=MD_CYCLES-1, state<=RUN.
- FSM:
  - IDLE: issue goes to RUN.
  - RUN: md_busy=1. Counter decrements each cycle regardless of stall_in/flush. Counter==0 goes to DONE.
  - DONE: md_done=1 and md_busy=0 for one cycle. Next state is IDLE, or RUN if a new issue occurs in that cycle (back-to-back ops).
- Non-HI/LO instructions flow through while in RUN (overlap permitted).
- Flush does not abort a running op.
- MD issue to md_done spans MD_CYCLES+1 edges.

Decomposition:
- Package alu_ctrl_pkg holds:
  - ALU control code localparams (ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI, NOP).
  - Funct and opcode constants.
  - ALUOp class constants.
  - FSM state encoding IDLE/RUN/DONE.
- Sub-module alu_ctrl_decode holds the pure combinational decode: ALUOp, Funct, Opcode -> code, is_md, is_hilo.
- alu_ctrl_seq holds the output register, FSM, counter and stall logic.

Test Plan:
- Reset: hold reset_n=0 two edges with valid add input -> ALUControl=0010, ctrl_valid=0, md_busy=0. Release, then ALUOp=10, Funct=100111 -> next edge ALUControl=1100, ctrl_valid=1.
- I-type: ALUOp=11, Opcode=001011 -> 1011. Opcode=001111 -> 1101. Opcode=000100 -> 0010.
- MD, MD_CYCLES=4: issue Funct=011010 at edge 0 -> md_start=1 after edge 0 only, md_op=10, md_busy=1 after edges 0-3, md_done=1 after edge 4. Meanwhile issue an add at edge 2 -> ctrl_valid=1, no stall.
- Hazard: mflo presented while RUN -> stall_req=1, ctrl_valid=0 each cycle. When state is DONE, stall_req=0 and mflo loads.
- Back-to-back: issue multu in the DONE cycle -> md_start pulses again, state returns to RUN, md_op=01.
- Flush/stall: flush with an MD issue -> no md_start, ctrl_valid=0. stall_in=1 for 3 cycles -> outputs frozen, while a running counter still decrements. reset_n=0 mid-RUN -> IDLE, md_busy=0, no md_done.
